// File: rtl/ips2l_uart_tx_32bit.sv
// ips2l_uart_tx_32bit
//
// Serialises one 32-bit word as four UART bytes, least significant byte first.
// Each byte is one start bit (0), eight data bits LSB first, an optional even
// parity bit, then STOP_BITS stop bits (1). Consecutive bytes of a word are sent
// back to back with no idle gap. Bit timing comes from the clk_en baud tick.
//
// Build options:
//   UART_TX_PARITY_EN  define to insert an even-parity bit after each data byte
//
// Parameters:
//   STOP_BITS  stop bits per byte, 1 or 2
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   clk_en    one-cycle baud tick, one tick per bit period
//   tx_data   word to transmit
//   tx_valid  tx_data is valid
//   tx_ready  module can accept a word (IDLE only)
//   txd       serial line, idles high, registered
//   tx_done   one-cycle pulse when the word has fully gone out

module ips2l_uart_tx_32bit #(
    parameter int unsigned STOP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        txd,
    output logic        tx_done
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StStart,
        StData,
        StStop,
        StDone
`ifdef UART_TX_PARITY_EN
        , StParity
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        stop_cnt_q, stop_cnt_d;
    logic        txd_q, txd_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        stop_last;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    // With one stop bit every stop tick is the last one.
    assign stop_last = (STOP_BITS == 2) ? stop_cnt_q : 1'b1;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            StIdle: begin
                // ready_q gates acceptance so the first cycle after reset cannot accept.
                if (tx_valid && ready_q) begin
                    state_d    = StWait;
                    shift_d    = tx_data;
                    bit_cnt_d  = 4'd0;
                    byte_cnt_d = 2'd0;
                    stop_cnt_d = 1'b0;
                end
            end
            StWait: begin
                if (clk_en) begin
                    state_d = StStart;
                    txd_d   = 1'b0;
                end
            end
            StStart: begin
                if (clk_en) begin
                    state_d   = StData;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[31:1]};
                    bit_cnt_d = 4'd1;
`ifdef UART_TX_PARITY_EN
                    parity_d  = shift_q[0];
`endif
                end
            end
            StData: begin
                if (clk_en) begin
                    if (bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = StParity;
                        txd_d     = parity_q;
`else
                        state_d   = StStop;
                        txd_d     = 1'b1;
`endif
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = {1'b0, shift_q[31:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef UART_TX_PARITY_EN
                        parity_d  = parity_q ^ shift_q[0];
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (clk_en) begin
                    state_d = StStop;
                    txd_d   = 1'b1;
                end
            end
`endif
            StStop: begin
                if (clk_en) begin
                    if (stop_last) begin
                        stop_cnt_d = 1'b0;
                        if (byte_cnt_q == 2'd3) begin
                            state_d    = StDone;
                            byte_cnt_d = 2'd0;
                            txd_d      = 1'b1;
                        end else begin
                            // Next byte's start bit begins on this same tick.
                            state_d    = StStart;
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            txd_d      = 1'b0;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                txd_d   = 1'b1;
            end
        endcase

        ready_d = (state_d == StIdle);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= 32'd0;
            bit_cnt_q  <= 4'd0;
            byte_cnt_q <= 2'd0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            txd_q      <= txd_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_ready = ready_q;
    assign txd      = txd_q;
    assign tx_done  = done_q;

endmodule
